macc: RTL and testbench

Matrix multiply-accumulate accelerator holding three 4x4 matrices (A, B, C) of 32-bit words. Each matrix is loaded and unloaded through its own 32-bit streaming port. Once A and B are both fully loaded, an internal engine computes C = C + A×B. The block sits as a memory-mapped-style compute slave driven by a host-side sequencer.

---
 rtl/macc.sv | 154 +++++++++++++++
 tb/tb_macc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/macc.sv
// macc: 4x4 matrix multiply-accumulate accelerator with three 32-bit
// streaming ports (A, B, C). Loading all 16 words of both A and B kicks
// off an engine that runs one MAC per cycle for 64 cycles.
// Build option: define MACC_ACCUM_EN to compute C = C + A*B; without it
// the engine computes C = A*B and overwrites prior C contents.
module macc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  wen,
  input  logic [2:0]  ren,
  input  logic [31:0] matrix_a_in,
  output logic [31:0] matrix_a_out,
  input  logic [31:0] matrix_b_in,
  output logic [31:0] matrix_b_out,
  input  logic [31:0] matrix_c_in,
  output logic [31:0] matrix_c_out
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q;
  logic [5:0]  step_q;
  logic [31:0] acc_q;
  logic        aFull_q;
  logic        bFull_q;

  logic [31:0] memA_q [16];
  logic [31:0] memB_q [16];
  logic [31:0] memC_q [16];

  logic [3:0]  wptrA_q, wptrB_q, wptrC_q;
  logic [3:0]  rptrA_q, rptrB_q, rptrC_q;
  logic [3:0]  wptrA_d, wptrB_d, wptrC_d;
  logic [3:0]  rptrA_d, rptrB_d, rptrC_d;

  logic        start;
  logic        running;
  logic        wrA, wrB, wrC;
  logic [1:0]  rowI, colJ, kIdx;
  logic [3:0]  aIdx, bIdx, cIdx;
  logic [31:0] accSeed;
  logic [31:0] accIn;
  logic [31:0] macSum;

  // The start cycle already counts as busy, so writes landing on it are dropped.
  assign start   = (state_q == IDLE) && aFull_q && bFull_q;
  assign running = (state_q == RUN) || start;

  assign wrA = wen[2] && !running;
  assign wrB = wen[1] && !running;
  assign wrC = wen[0] && !running;

  // Step counter walks i, j, k in row-major order with k innermost.
  assign rowI = step_q[5:4];
  assign colJ = step_q[3:2];
  assign kIdx = step_q[1:0];
  assign aIdx = {rowI, kIdx};
  assign bIdx = {kIdx, colJ};
  assign cIdx = {rowI, colJ};

`ifdef MACC_ACCUM_EN
  assign accSeed = memC_q[cIdx];
`else
  assign accSeed = 32'd0;
`endif

  assign accIn  = (kIdx == 2'd0) ? accSeed : acc_q;
  assign macSum = accIn + memA_q[aIdx] * memB_q[bIdx];

  assign matrix_a_out = memA_q[rptrA_q];
  assign matrix_b_out = memB_q[rptrB_q];
  assign matrix_c_out = memC_q[rptrC_q];

  // Next pointer values: writes advance only when accepted, reads always.
  always_comb begin
    wptrA_d = wrA    ? wptrA_q + 4'd1 : wptrA_q;
    wptrB_d = wrB    ? wptrB_q + 4'd1 : wptrB_q;
    wptrC_d = wrC    ? wptrC_q + 4'd1 : wptrC_q;
    rptrA_d = ren[2] ? rptrA_q + 4'd1 : rptrA_q;
    rptrB_d = ren[1] ? rptrB_q + 4'd1 : rptrB_q;
    rptrC_d = ren[0] ? rptrC_q + 4'd1 : rptrC_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptrA_q <= '0;
      wptrB_q <= '0;
      wptrC_q <= '0;
      rptrA_q <= '0;
      rptrB_q <= '0;
      rptrC_q <= '0;
    end else begin
      wptrA_q <= wptrA_d;
      wptrB_q <= wptrB_d;
      wptrC_q <= wptrC_d;
      rptrA_q <= rptrA_d;
      rptrB_q <= rptrB_d;
      rptrC_q <= rptrC_d;
    end
  end

  // Matrix storage; C is written by the host when idle or by the engine on each k==3 step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 16; n++) begin
        memA_q[n] <= '0;
        memB_q[n] <= '0;
        memC_q[n] <= '0;
      end
    end else begin
      if (wrA) memA_q[wptrA_q] <= matrix_a_in;
      if (wrB) memB_q[wptrB_q] <= matrix_b_in;
      if (wrC) memC_q[wptrC_q] <= matrix_c_in;
      if (running && kIdx == 2'd3) memC_q[cIdx] <= macSum;
    end
  end

  // Engine FSM: tracks loaded flags, launches the 64-step MAC sweep and returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      aFull_q <= 1'b0;
      bFull_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            step_q  <= 6'd1;
            acc_q   <= macSum;
            aFull_q <= 1'b0;
            bFull_q <= 1'b0;
          end else begin
            if (wrA && wptrA_q == 4'd15) aFull_q <= 1'b1;
            if (wrB && wptrB_q == 4'd15) bFull_q <= 1'b1;
          end
        end
        RUN: begin
          acc_q  <= macSum;
          step_q <= step_q + 6'd1;
          if (step_q == 6'd63) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_macc.sv
// tb_macc: directed testbench for macc. Expected values are hand-derived
// from the matrix contents loaded in each step.
module tb_macc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  wen;
   logic [2:0]  ren;
   logic [31:0] aIn, bIn, cIn;
   logic [31:0] aOut, bOut, cOut;

   int checks = 0;
   int failures = 0;

`ifdef MACC_ACCUM_EN
   localparam logic [31:0] ACCUM_EXPECT = 32'd4;
`else
   localparam logic [31:0] ACCUM_EXPECT = 32'd2;
`endif

   macc dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wen          (wen),
      .ren          (ren),
      .matrix_a_in  (aIn),
      .matrix_a_out (aOut),
      .matrix_b_in  (bIn),
      .matrix_b_out (bOut),
      .matrix_c_in  (cIn),
      .matrix_c_out (cOut)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] identityWord(input int idx);
      return (idx % 5 == 0) ? 32'd1 : 32'd0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] w, input logic [2:0] r,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      wen = w;
      ren = r;
      aIn = a;
      bIn = b;
      cIn = c;
      tick();
      wen = 3'b000;
      ren = 3'b000;
   endtask

   task automatic doReset();
      wen   = 3'b000;
      ren   = 3'b000;
      aIn   = '0;
      bIn   = '0;
      cIn   = '0;
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic loadIdentityA();
      for (int n = 0; n < 16; n++) applyStimulus(3'b100, 3'b000, identityWord(n), '0, '0);
   endtask

   task automatic loadConstB(input logic [31:0] v);
      for (int n = 0; n < 16; n++) applyStimulus(3'b010, 3'b000, '0, v, '0);
   endtask

   task automatic readCheckC(input string tag, input logic [31:0] v);
      for (int n = 0; n < 16; n++) begin
         checkOutput($sformatf("%s[%0d]", tag, n), cOut, v);
         applyStimulus(3'b000, 3'b001, '0, '0, '0);
      end
   endtask

   initial begin
      // Reset values on all outputs.
      doReset();
      checkOutput("reset_a", aOut, 32'd0);
      checkOutput("reset_b", bOut, 32'd0);
      checkOutput("reset_c", cOut, 32'd0);

      // Single write is visible on the next cycle when pointers coincide.
      applyStimulus(3'b100, 3'b000, 32'hdeadbeef, '0, '0);
      @(negedge clk);
      checkOutput("single_write_a", aOut, 32'hdeadbeef);
      checkOutput("single_write_b", bOut, 32'd0);
      checkOutput("single_write_c", cOut, 32'd0);

      // Stream A = 1..16 and read it back, including the read-pointer wrap.
      doReset();
      for (int n = 0; n < 16; n++) applyStimulus(3'b100, 3'b000, n + 1, '0, '0);
      checkOutput("stream_a_first", aOut, 32'd1);
      for (int p = 1; p <= 16; p++) begin
         applyStimulus(3'b000, 3'b100, '0, '0, '0);
         checkOutput($sformatf("stream_a_step%0d", p), aOut, (p % 16) + 1);
      end

      // C = 0, A = identity, B = all 2 gives C = all 2.
      doReset();
      for (int n = 0; n < 16; n++) applyStimulus(3'b001, 3'b000, '0, '0, 32'd0);
      loadIdentityA();
      loadConstB(32'd2);
      repeat (64) tick();
      readCheckC("mul2_c", 32'd2);

      // Reload A and B without touching C; hammer all writes while busy.
      loadIdentityA();
      loadConstB(32'd2);
      for (int n = 0; n < 10; n++) applyStimulus(3'b111, 3'b000, 32'h12345678, 32'h12345678, 32'h12345678);
      repeat (54) tick();
      readCheckC("accum_c", ACCUM_EXPECT);
      for (int n = 0; n < 16; n++) begin
         checkOutput($sformatf("busy_a[%0d]", n), aOut, identityWord(n));
         checkOutput($sformatf("busy_b[%0d]", n), bOut, 32'd2);
         applyStimulus(3'b000, 3'b110, '0, '0, '0);
      end
      // Write pointers must still be at 0: new words land where read pointers sit.
      applyStimulus(3'b111, 3'b000, 32'h000000aa, 32'h000000bb, 32'h000000cc);
      checkOutput("wptr_a", aOut, 32'h000000aa);
      checkOutput("wptr_b", bOut, 32'h000000bb);
      checkOutput("wptr_c", cOut, 32'h000000cc);

      // Reset in the middle of a compute clears everything immediately.
      doReset();
      loadIdentityA();
      loadConstB(32'd2);
      checkOutput("precompute_a", aOut, 32'd1);
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_a", aOut, 32'd0);
      checkOutput("midreset_b", bOut, 32'd0);
      checkOutput("midreset_c", cOut, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      loadIdentityA();
      loadConstB(32'd3);
      repeat (64) tick();
      readCheckC("after_reset_c", 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
